// File: rtl/pe_cu_param.sv
// Parametrised PE controller: sequences accumulate, result-latch and memory-write phases for one convolution pass.
// Optional feature macro PE_CU_PERF_EN adds a saturating stall_cycles output.
module pe_cu_param #(
    parameter int unsigned MAC_LEN     = 16,
    parameter int unsigned RES_DEPTH   = 4,
    parameter int unsigned NUM_RESULTS = 169,
    parameter int unsigned IMG_SIZE    = 16,
    parameter int unsigned KERNEL_W    = 4,
    parameter int unsigned CW          = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          in_valid,
    input  logic          wr_ack,
    output logic          busy,
    output logic          done,
    output logic          init,
    output logic          acc_en,
    output logic          rst_acc,
    output logic          res_buffer_en,
    output logic          rst_res_reg,
    output logic          wr_en,
    output logic          wr_file,
    output logic [CW-1:0] img_buffer_index,
    output logic [CW-1:0] buffer_cntr,
    output logic [CW-1:0] res_index,
    output logic [CW-1:0] wr_adr
`ifdef PE_CU_PERF_EN
    ,
    output logic [31:0]   stall_cycles
`endif
);

    localparam int unsigned   RW        = $clog2(NUM_RESULTS + 1);
    localparam logic [RW-1:0] RES_TOTAL = RW'(NUM_RESULTS);
    localparam logic [CW-1:0] MAC_LAST  = CW'(MAC_LEN - 1);
    localparam logic [CW-1:0] GRP_LAST  = CW'(RES_DEPTH - 1);
    localparam logic [CW-1:0] SKIP      = CW'(KERNEL_W - 1);
    localparam int unsigned   SKIP_POS  = IMG_SIZE - (KERNEL_W - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_MAC, S_LD, S_WR, S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] buf_q, buf_d;
    logic [CW-1:0] ridx_q, ridx_d;
    logic [CW-1:0] img_q, img_d;
    logic [CW-1:0] adr_q, adr_d;
    logic [RW-1:0] cnt_q, cnt_d;

    logic [CW-1:0] img_inc;
    logic          row_end;
    logic          aborting;

    // Window base advances by one; landing on the row tail jumps to the next row.
    assign img_inc  = img_q + CW'(1);
    assign row_end  = ((32'(img_inc) % IMG_SIZE) == SKIP_POS);
    assign aborting = abort && (state_q != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            ridx_q  <= '0;
            img_q   <= '0;
            adr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            ridx_q  <= ridx_d;
            img_q   <= img_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and counter updates; abort freezes every counter.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        ridx_d  = ridx_q;
        img_d   = img_q;
        adr_d   = adr_q;
        cnt_d   = cnt_q;
        if (aborting) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_d = S_INIT;
                end
                S_INIT: begin
                    buf_d   = '0;
                    ridx_d  = '0;
                    img_d   = '0;
                    adr_d   = '0;
                    cnt_d   = '0;
                    state_d = S_MAC;
                end
                S_MAC: begin
                    if (in_valid) begin
                        if (buf_q == MAC_LAST) begin
                            buf_d   = '0;
                            state_d = S_LD;
                        end else begin
                            buf_d = buf_q + CW'(1);
                        end
                    end
                end
                S_LD: begin
                    ridx_d  = ridx_q + CW'(1);
                    cnt_d   = cnt_q + RW'(1);
                    img_d   = row_end ? (img_inc + SKIP) : img_inc;
                    state_d = ((ridx_q == GRP_LAST) || (cnt_d == RES_TOTAL)) ? S_WR : S_MAC;
                end
                S_WR: begin
                    if (wr_ack) begin
                        adr_d   = adr_q + CW'(1);
                        ridx_d  = '0;
                        state_d = (cnt_q == RES_TOTAL) ? S_DONE : S_MAC;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        init          = 1'b0;
        acc_en        = 1'b0;
        rst_acc       = 1'b0;
        res_buffer_en = 1'b0;
        rst_res_reg   = 1'b0;
        wr_en         = 1'b0;
        wr_file       = 1'b0;
        busy          = (state_q != S_IDLE);
        case (state_q)
            S_INIT: init = 1'b1;
            S_MAC:  acc_en = in_valid;
            S_LD: begin
                res_buffer_en = 1'b1;
                rst_acc       = 1'b1;
            end
            S_WR: begin
                wr_en       = 1'b1;
                rst_res_reg = wr_ack;
            end
            S_DONE: begin
                done    = 1'b1;
                wr_file = 1'b1;
            end
            default: ;
        endcase
    end

    assign img_buffer_index = img_q;
    assign buffer_cntr      = buf_q;
    assign res_index        = ridx_q;
    assign wr_adr           = adr_q;

`ifdef PE_CU_PERF_EN
    logic [31:0] stall_q, stall_d;

    // Counts operand and write-ack wait cycles, saturating.
    always_comb begin
        stall_d = stall_q;
        if (!aborting) begin
            if (state_q == S_INIT) begin
                stall_d = '0;
            end else if ((((state_q == S_MAC) && !in_valid) || ((state_q == S_WR) && !wr_ack))
                         && (stall_q != '1)) begin
                stall_d = stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_q <= '0;
        else      stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pe_cu_param.sv
// Randomised self-checking bench for pe_cu_param: a pass-level program model predicts every output each cycle.
module tb_pe_cu_param;

    typedef struct packed {
        logic busy, done, init, acc_en, rst_acc, res_buffer_en, rst_res_reg, wr_en, wr_file;
        logic [7:0] img, bc, ri, adr;
        logic [31:0] stall;
    } obs_t;

    typedef struct packed {
        logic busy, done, init, acc_en, rst_acc, res_buffer_en, rst_res_reg, wr_en, wr_file;
    } flags_t;

    logic clk = 1'b0;
    logic rst, start1, start2, abort, in_valid, wr_ack;
    logic busy1, done1, init1, acc1, racc1, rbe1, rrr1, wre1, wrf1;
    logic busy2, done2, init2, acc2, racc2, rbe2, rrr2, wre2, wrf2;
    logic [7:0] img1, bc1, ri1, adr1, img2, bc2, ri2, adr2;
    logic [31:0] stall1, stall2;
    obs_t o1, o2, o;
    bit sel;

    always #5 clk = ~clk;

    pe_cu_param u_big (
        .clk(clk), .rst(rst), .start(start1), .abort(abort), .in_valid(in_valid), .wr_ack(wr_ack),
        .busy(busy1), .done(done1), .init(init1), .acc_en(acc1), .rst_acc(racc1),
        .res_buffer_en(rbe1), .rst_res_reg(rrr1), .wr_en(wre1), .wr_file(wrf1),
        .img_buffer_index(img1), .buffer_cntr(bc1), .res_index(ri1), .wr_adr(adr1)
`ifdef PE_CU_PERF_EN
        , .stall_cycles(stall1)
`endif
    );

    pe_cu_param #(.MAC_LEN(9), .RES_DEPTH(3), .NUM_RESULTS(7), .IMG_SIZE(5), .KERNEL_W(3), .CW(8)) u_small (
        .clk(clk), .rst(rst), .start(start2), .abort(abort), .in_valid(in_valid), .wr_ack(wr_ack),
        .busy(busy2), .done(done2), .init(init2), .acc_en(acc2), .rst_acc(racc2),
        .res_buffer_en(rbe2), .rst_res_reg(rrr2), .wr_en(wre2), .wr_file(wrf2),
        .img_buffer_index(img2), .buffer_cntr(bc2), .res_index(ri2), .wr_adr(adr2)
`ifdef PE_CU_PERF_EN
        , .stall_cycles(stall2)
`endif
    );

`ifndef PE_CU_PERF_EN
    assign stall1 = '0;
    assign stall2 = '0;
`endif

    assign o1 = {busy1, done1, init1, acc1, racc1, rbe1, rrr1, wre1, wrf1, img1, bc1, ri1, adr1, stall1};
    assign o2 = {busy2, done2, init2, acc2, racc2, rbe2, rrr2, wre2, wrf2, img2, bc2, ri2, adr2, stall2};
    assign o  = sel ? o2 : o1;

    // Model state: expected flags plus what each counter must read.
    flags_t      e;
    logic [7:0]  bc, ri, img, adr;
    int          res;
    logic [31:0] stall_m;
    int m_mac, m_dep, m_num, m_img, m_kw;

    int iv_pct, ack_pct, stall_r, stall_k, stall_n, nack_n, nack_run;
    int n_chk = 0, n_pass = 0;
    int cyc = 0, start_cyc, done_cyc;
    bit check_en = 1'b0;

    int n_done, n_wr_cyc, first_wr_len, n_acks, n_ld;
    logic [7:0] last_adr, last_ack_ri;
    logic [7:0] ld_img [16];
    logic [7:0] grp [4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("busy", 32'(o.busy), 32'(e.busy));
            chk("done", 32'(o.done), 32'(e.done));
            chk("init", 32'(o.init), 32'(e.init));
            chk("acc_en", 32'(o.acc_en), 32'(e.acc_en));
            chk("rst_acc", 32'(o.rst_acc), 32'(e.rst_acc));
            chk("res_buffer_en", 32'(o.res_buffer_en), 32'(e.res_buffer_en));
            chk("rst_res_reg", 32'(o.rst_res_reg), 32'(e.rst_res_reg));
            chk("wr_en", 32'(o.wr_en), 32'(e.wr_en));
            chk("wr_file", 32'(o.wr_file), 32'(e.wr_file));
            chk("img_buffer_index", 32'(o.img), 32'(img));
            chk("buffer_cntr", 32'(o.bc), 32'(bc));
            chk("res_index", 32'(o.ri), 32'(ri));
            chk("wr_adr", 32'(o.adr), 32'(adr));
`ifdef PE_CU_PERF_EN
            chk("stall_cycles", o.stall, stall_m);
`endif
            if (o.done === 1'b1) begin n_done++; done_cyc = cyc; end
            if (o.wr_en === 1'b1) begin
                n_wr_cyc++;
                last_adr = o.adr;
                if (o.adr == 8'd0) first_wr_len++;
                if (o.rst_res_reg === 1'b1) begin
                    if (n_acks < 4) grp[n_acks] = o.ri;
                    last_ack_ri = o.ri;
                    n_acks++;
                end
            end
            if (o.res_buffer_en === 1'b1) begin
                if (n_ld < 16) ld_img[n_ld] = o.img;
                n_ld++;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_clear();
        e = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin exp_clear(); cycle(); end
    endtask

    task automatic set_start(input logic v);
        if (sel) start2 = v; else start1 = v;
    endtask

    task automatic set_sel(input bit s);
        sel = s;
        m_mac = s ? 9 : 16; m_dep = s ? 3 : 4; m_num = s ? 7 : 169;
        m_img = s ? 5 : 16; m_kw = s ? 3 : 4;
        bc = '0; ri = '0; img = '0; adr = '0; res = 0; stall_m = '0;
    endtask

    task automatic knobs(input int ivp, input int ackp);
        iv_pct = ivp; ack_pct = ackp; stall_n = 0; stall_r = -1; stall_k = -1; nack_n = 0; nack_run = 0;
    endtask

    task automatic clear_stats();
        n_done = 0; n_wr_cyc = 0; first_wr_len = 0; n_acks = 0; n_ld = 0;
        last_adr = '0; last_ack_ri = '0; done_cyc = 0;
        for (int i = 0; i < 16; i++) ld_img[i] = '0;
        for (int i = 0; i < 4; i++) grp[i] = '0;
    endtask

    // Window base after n results: rows of (IMG_SIZE-KERNEL_W+1) positions, each row IMG_SIZE apart.
    function automatic logic [7:0] img_model(input int n);
        int w;
        w = m_img - (m_kw - 1);
        return 8'((n / w) * m_img + (n % w));
    endfunction

    task automatic pick_iv(input int r, input int k, output bit iv);
        if (r == stall_r && k == stall_k && stall_n > 0) begin
            stall_n--; iv = 1'b0;
        end else begin
            iv = (iv_pct >= 100) ? 1'b1 : ($urandom_range(99) < iv_pct);
        end
    endtask

    task automatic pick_ack(output bit ack);
        if (nack_n > 0) begin
            nack_n--; ack = 1'b0;
        end else if (ack_pct >= 100 || nack_run >= 8) begin
            nack_run = 0; ack = 1'b1;
        end else begin
            ack = ($urandom_range(99) < ack_pct);
            nack_run = ack ? 0 : nack_run + 1;
        end
    endtask

    // One pass as a program: INIT, then per result MAC_LEN valid operands and a latch, writes per full group.
    task automatic run_pass(input int abort_r, input int abort_k, input bit rst_wr);
        int k;
        bit iv, ack;
        exp_clear();
        set_start(1'b1);
        cycle();
        set_start(1'b0);
        start_cyc = cyc;
        exp_clear(); e.busy = 1; e.init = 1;
        cycle();
        bc = '0; ri = '0; img = '0; adr = '0; res = 0; stall_m = '0;
        for (int r = 0; r < m_num; r++) begin
            k = 0;
            while (k < m_mac) begin
                pick_iv(r, k, iv);
                in_valid = iv;
                set_start($urandom_range(7) == 0);
                exp_clear(); e.busy = 1; e.acc_en = iv; bc = 8'(k);
                if (r == abort_r && k == abort_k) begin
                    abort = 1'b1;
                    cycle();
                    abort = 1'b0; set_start(1'b0); in_valid = 1'b0;
                    exp_clear();
                    return;
                end
                cycle();
                if (iv) k++;
                else if (stall_m != '1) stall_m++;
            end
            set_start(1'b0); in_valid = 1'b0; bc = '0;
            exp_clear(); e.busy = 1; e.res_buffer_en = 1; e.rst_acc = 1;
            cycle();
            res++; ri = ri + 8'd1; img = img_model(res);
            if (ri == 8'(m_dep) || res == m_num) begin
                forever begin
                    if (rst_wr) ack = 1'b0; else pick_ack(ack);
                    wr_ack = ack;
                    exp_clear(); e.busy = 1; e.wr_en = 1; e.rst_res_reg = ack;
                    cycle();
                    if (rst_wr) begin
                        check_en = 1'b0; wr_ack = 1'b0; rst = 1'b0;
                        #1;
                        chk("rst_busy", 32'(o.busy), 32'd0);
                        chk("rst_wr_en", 32'(o.wr_en), 32'd0);
                        chk("rst_rst_res_reg", 32'(o.rst_res_reg), 32'd0);
                        chk("rst_img", 32'(o.img), 32'd0);
                        chk("rst_res_index", 32'(o.ri), 32'd0);
                        chk("rst_wr_adr", 32'(o.adr), 32'd0);
                        rst = 1'b1;
                        bc = '0; ri = '0; img = '0; adr = '0; res = 0; stall_m = '0;
                        exp_clear(); check_en = 1'b1;
                        return;
                    end
                    if (ack) begin adr = adr + 8'd1; ri = '0; break; end
                    if (stall_m != '1) stall_m++;
                end
                wr_ack = 1'b0;
            end
        end
        exp_clear(); e.busy = 1; e.done = 1; e.wr_file = 1;
        cycle();
        exp_clear();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start1 = 1'b0; start2 = 1'b0; abort = 1'b0; in_valid = 1'b0; wr_ack = 1'b0;
        set_sel(1'b0); exp_clear(); knobs(100, 100); clear_stats();
        @(posedge clk); #1;
        check_en = 1'b1;
        idle(3);
        rst = 1'b1;
        idle(3);

        // Defaults, every operand valid, every write acked at once.
        clear_stats(); run_pass(-1, 0, 1'b0); idle(2);
        chk("done_latency", 32'(done_cyc - start_cyc), 32'd2917);
        chk("done_pulses", 32'(n_done), 32'd1);
        chk("wr_en_cycles", 32'(n_wr_cyc), 32'd43);
        chk("last_wr_adr", 32'(last_adr), 32'd42);
        chk("final_group_slots", 32'(last_ack_ri), 32'd1);
        chk("img_at_ld12", 32'(ld_img[12]), 32'd12);
        chk("img_at_ld13", 32'(ld_img[13]), 32'd16);
        chk("img_at_ld14", 32'(ld_img[14]), 32'd17);
        chk("final_img", 32'(o.img), 32'd208);
        chk("final_wr_adr", 32'(o.adr), 32'd43);

        // Five-cycle operand stall at buffer_cntr 7.
        knobs(100, 100); stall_r = 3; stall_k = 7; stall_n = 5;
        clear_stats(); run_pass(-1, 0, 1'b0); idle(2);
        chk("stall_latency", 32'(done_cyc - start_cyc), 32'd2922);
`ifdef PE_CU_PERF_EN
        chk("stall_count", o.stall, 32'd5);
`endif

        // Write backpressure on the first write.
        knobs(100, 100); nack_n = 3;
        clear_stats(); run_pass(-1, 0, 1'b0); idle(2);
        chk("bp_first_write_len", 32'(first_wr_len), 32'd4);
        chk("bp_wr_en_cycles", 32'(n_wr_cyc), 32'd46);
        chk("bp_latency", 32'(done_cyc - start_cyc), 32'd2920);

        // Random operand and ack traffic.
        knobs(75, 60); clear_stats(); run_pass(-1, 0, 1'b0); idle(2);
        chk("rand_done_pulses", 32'(n_done), 32'd1);

        // Abort during result 20, then a full restart.
        knobs(90, 80); clear_stats(); run_pass(20, 5, 1'b0); idle(3);
        chk("abort_no_done", 32'(n_done), 32'd0);
        chk("abort_img_held", 32'(o.img), 32'd23);
        chk("abort_adr_held", 32'(o.adr), 32'd5);
        knobs(80, 70); clear_stats(); run_pass(-1, 0, 1'b0); idle(2);
        chk("restart_done_pulses", 32'(n_done), 32'd1);
        chk("restart_final_img", 32'(o.img), 32'd208);

        // Asynchronous reset while a write is pending.
        knobs(100, 100); clear_stats(); run_pass(-1, 0, 1'b1); idle(3);
        chk("rst_no_done", 32'(n_done), 32'd0);

        // Small parameter set.
        set_sel(1'b1); knobs(100, 100); clear_stats(); run_pass(-1, 0, 1'b0); idle(2);
        chk("small_latency", 32'(done_cyc - start_cyc), 32'd74);
        chk("small_writes", 32'(n_acks), 32'd3);
        chk("small_group0", 32'(grp[0]), 32'd3);
        chk("small_group1", 32'(grp[1]), 32'd3);
        chk("small_group2", 32'(grp[2]), 32'd1);
        chk("small_final_img", 32'(o.img), 32'd11);
        knobs(70, 70); clear_stats(); run_pass(-1, 0, 1'b0); idle(2);
        chk("small_rand_done", 32'(n_done), 32'd1);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
